fb_double_buffer_writer: RTL

//  Consumes the rasterised pixel stream from GPU_top and writes it into a

---
 rtl/fb_double_buffer_writer_if.sv | 29 ++
 rtl/fb_double_buffer_writer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fb_double_buffer_writer_if.sv
// Pixel-stream, framebuffer-write and scanout-handshake signals of the
// double-buffered framebuffer writer. master = GPU/scanout side, slave = writer.
interface fb_double_buffer_writer_if #(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned ADDR_W  = 19
);
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               frame_end;
    logic               vsync;
    logic               render_ready;
    logic               fb_wr_en;
    logic [ADDR_W:0]    fb_wr_addr;
    logic [COLOR_W-1:0] fb_wr_data;
    logic               display_bank;
    logic [15:0]        drop_count;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, frame_end, vsync,
        input  render_ready, fb_wr_en, fb_wr_addr, fb_wr_data, display_bank, drop_count
    );
    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, frame_end, vsync,
        output render_ready, fb_wr_en, fb_wr_addr, fb_wr_data, display_bank, drop_count
    );
endinterface

// File: rtl/fb_double_buffer_writer.sv
// Writes the GPU pixel stream into the render bank of a double-buffered framebuffer,
// swaps banks on vsync after frame_end, and clears the new render bank before each frame.
module fb_double_buffer_writer #(
    parameter int unsigned         WIDTH       = 800,
    parameter int unsigned         HEIGHT      = 600,
    parameter int unsigned         COORD_W     = 11,
    parameter int unsigned         COLOR_W     = 8,
    parameter int unsigned         ADDR_W      = 19,
    parameter logic [COLOR_W-1:0]  CLEAR_COLOR = '0
) (
    input logic                      clk,
    input logic                      reset,
    fb_double_buffer_writer_if.slave bus
);
    localparam int unsigned NPIX   = WIDTH * HEIGHT;
    localparam int unsigned PROD_W = COORD_W + $clog2(WIDTH + 1);

    typedef enum logic [1:0] {CLEAR, ACCEPT, WAIT_SWAP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                disp_bank_q, disp_bank_d;
    logic                render_ready_q, render_ready_d;
    logic                s1_vld_q, s1_vld_d;
    logic                s1_keep_q, s1_keep_d;
    logic [ADDR_W-1:0]   s1_x_q, s1_x_d;
    logic [ADDR_W-1:0]   s1_base_q, s1_base_d;
    logic [COLOR_W-1:0]  s1_color_q, s1_color_d;
    logic [1:0]          fe_pipe_q, fe_pipe_d;
    logic                fb_wr_en_q, fb_wr_en_d;
    logic [ADDR_W:0]     fb_wr_addr_q, fb_wr_addr_d;
    logic [COLOR_W-1:0]  fb_wr_data_q, fb_wr_data_d;
    logic [15:0]         drop_count_q, drop_count_d;

    logic [PROD_W-1:0]   row_base;
    logic                in_bounds;
    logic                opaque;
    logic                accept;

    always_comb begin
        state_d        = state_q;
        clr_addr_d     = clr_addr_q;
        disp_bank_d    = disp_bank_q;
        s1_x_d         = s1_x_q;
        s1_base_d      = s1_base_q;
        s1_color_d     = s1_color_q;
        fb_wr_en_d     = 1'b0;
        fb_wr_addr_d   = fb_wr_addr_q;
        fb_wr_data_d   = fb_wr_data_q;
        drop_count_d   = drop_count_q;

        // Product is wide enough for any COORD_W row, so the bounds test sees the true value.
        row_base  = PROD_W'(bus.pix_y) * PROD_W'(WIDTH);
        in_bounds = (32'(bus.pix_x) < WIDTH) && (32'(bus.pix_y) < HEIGHT) &&
                    (row_base < PROD_W'(NPIX));
        opaque    = (bus.pix_color != '0);
        accept    = bus.pix_valid && render_ready_q;

        s1_vld_d  = accept;
        s1_keep_d = accept && in_bounds && opaque;
        if (accept) begin
            s1_x_d     = ADDR_W'(bus.pix_x);
            s1_base_d  = ADDR_W'(row_base);
            s1_color_d = bus.pix_color;
        end

        if (bus.pix_valid && (!render_ready_q || (opaque && !in_bounds)) &&
            drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;

        if (s1_vld_q && s1_keep_q) begin
            fb_wr_en_d   = 1'b1;
            fb_wr_addr_d = {~disp_bank_q, s1_base_q + s1_x_q};
            fb_wr_data_d = s1_color_q;
        end

        // frame_end travels with the pixel pipeline so the final write lands first.
        fe_pipe_d = {fe_pipe_q[0], bus.frame_end && (state_q == ACCEPT)};

        case (state_q)
            CLEAR: begin
                fb_wr_en_d   = 1'b1;
                fb_wr_addr_d = {~disp_bank_q, clr_addr_q};
                fb_wr_data_d = CLEAR_COLOR;
                if (clr_addr_q == ADDR_W'(NPIX - 1)) begin
                    state_d    = ACCEPT;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ACCEPT: begin
                if (fe_pipe_q[1]) state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (bus.vsync) begin
                    disp_bank_d = ~disp_bank_q;
                    state_d     = CLEAR;
                    clr_addr_d  = '0;
                end
            end
            default: state_d = CLEAR;
        endcase

        render_ready_d = (state_d == ACCEPT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= CLEAR;
            clr_addr_q     <= '0;
            disp_bank_q    <= 1'b0;
            render_ready_q <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_keep_q      <= 1'b0;
            s1_x_q         <= '0;
            s1_base_q      <= '0;
            s1_color_q     <= '0;
            fe_pipe_q      <= '0;
            fb_wr_en_q     <= 1'b0;
            fb_wr_addr_q   <= '0;
            fb_wr_data_q   <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            disp_bank_q    <= disp_bank_d;
            render_ready_q <= render_ready_d;
            s1_vld_q       <= s1_vld_d;
            s1_keep_q      <= s1_keep_d;
            s1_x_q         <= s1_x_d;
            s1_base_q      <= s1_base_d;
            s1_color_q     <= s1_color_d;
            fe_pipe_q      <= fe_pipe_d;
            fb_wr_en_q     <= fb_wr_en_d;
            fb_wr_addr_q   <= fb_wr_addr_d;
            fb_wr_data_q   <= fb_wr_data_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign bus.render_ready = render_ready_q;
    assign bus.fb_wr_en     = fb_wr_en_q;
    assign bus.fb_wr_addr   = fb_wr_addr_q;
    assign bus.fb_wr_data   = fb_wr_data_q;
    assign bus.display_bank = disp_bank_q;
    assign bus.drop_count   = drop_count_q;
endmodule
